// File: rtl/if_id_fifo.sv
// IF/ID pipeline buffer: a small circular FIFO between fetch and decode with
// per-side stall control, flush, and zero (NOP bubble) outputs when empty.
module if_id_fifo #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int DEPTH   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_W-1:0]        stall,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [ADDR_W-1:0]         if_pc,
    input  logic [INST_W-1:0]         if_inst,
    output logic                      if_ready,
    output logic                      id_valid,
    output logic [ADDR_W-1:0]         id_pc,
    output logic [INST_W-1:0]         id_inst,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;

    // Handshake: an entry transfers in when if_valid && if_ready and the fetch
    // side is not stalled; the head leaves when id_valid and decode is not
    // stalled. if_ready depends on registered occupancy only (no bypass).
    assign if_ready = (cnt < CW'(DEPTH));
    assign id_valid = (cnt != '0);
    assign push     = if_valid && if_ready && !stall[STAGE] && !flush;
    assign pop      = id_valid && !stall[STAGE+1] && !flush;

    assign id_pc    = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst  = id_valid ? inst_mem[rd_ptr] : '0;
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage is never cleared; only pointers and count are visible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr]   <= if_pc;
            inst_mem[wr_ptr] <= if_inst;
        end
    end

endmodule

// File: doc/if_id_fifo.md
IF_ID_FIFO -- requirements
Module: if_id_fifo

Interface
REQ-001 Parameter ADDR_W, 32, width of the PC field.
REQ-002 Parameter INST_W, 32, width of the instruction field.
REQ-003 Parameter DEPTH, 2, number of buffer entries; a power of two, 2..8.
REQ-004 Parameter STALL_W, 6, width of the pipeline stall vector.
REQ-005 Parameter STAGE, 1, stall-vector index of the fetch side; STAGE+1 is the decode side; STAGE+1 < STALL_W.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset (RstEnable = 1), sampled on the rising edge of clk.
REQ-008 stall  input  STALL_W  pipeline stall vector; bit = 1 means Stop.
REQ-009 flush  input  1  discards all buffered entries (branch or exception redirect).
REQ-010 if_valid  input  1  fetch side presents a valid PC/instruction pair.
REQ-011 if_pc  input  ADDR_W  fetched PC.
REQ-012 if_inst  input  INST_W  fetched instruction.
REQ-013 if_ready  output  1  buffer can accept an entry this cycle.
REQ-014 id_valid  output  1  id_pc/id_inst hold a real instruction.
REQ-015 id_pc  output  ADDR_W  head-entry PC, or zero when empty.
REQ-016 id_inst  output  INST_W  head-entry instruction, or zero (NOP bubble) when empty.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries, each ADDR_W+INST_W bits, with read pointer, write pointer and occupancy count.
REQ-019 if_ready SHALL equal (count < DEPTH); it is combinational from registered state only.
REQ-020 Push SHALL occur when if_valid=1, if_ready=1, stall[STAGE]=0, flush=0 and rst=0; the pair is written at the write pointer, which then advances modulo DEPTH.
REQ-021 Pop SHALL occur when count>0, stall[STAGE+1]=0, flush=0 and rst=0; the read pointer then advances modulo DEPTH.
REQ-022 id_valid SHALL equal (count>0); id_pc/id_inst SHALL show the entry at the read pointer when count>0, else all zeros.
REQ-023 Latency: a push into an empty buffer SHALL appear on id_* with id_valid=1 on the cycle after the push edge.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-025 Full: with count=DEPTH, if_ready=0 and if_valid is ignored, even if a pop occurs that cycle; there is no bypass.
REQ-026 Empty: with count=0, no pop occurs, the outputs read zero and stall[STAGE+1] has no effect.
REQ-027 Decode stall: with stall[STAGE+1]=1, the head entry and all id_* outputs SHALL hold stable; pushes continue until full.
REQ-028 Fetch stall: with stall[STAGE]=1, no push occurs regardless of if_valid; the head entry may still pop.
REQ-029 Flush: at the edge, count, the read pointer and the write pointer SHALL all go to 0; the next cycle shows id_valid=0 and zeros.
REQ-030 Flush SHALL take priority over a simultaneous push or pop; the presented fetch pair is discarded.
REQ-031 Pointer wrap SHALL be seamless; entry order is strictly FIFO across the DEPTH-1 to 0 wrap.
REQ-032 Entry contents need no clearing on flush or reset; only count and the pointers are architecturally visible.

Reset
REQ-033 While rst=1 at a rising edge: count=0, read pointer=0, write pointer=0.
REQ-034 After reset: id_valid=0, id_pc=0, id_inst=0, if_ready=1.
REQ-035 Reset SHALL take priority over flush, push and pop.
REQ-036 Reset asserted mid-operation, with a partly full buffer, SHALL discard all entries within one edge.
REQ-037 Behaviour is undefined only before the first reset.

Verification
REQ-038 Reset then a single push of pc=0x00000004, inst=0x24010001 -> next cycle id_valid=1, id_pc=0x00000004, id_inst=0x24010001, count=1.
REQ-039 DEPTH=2: push A and B with stall[2]=1 -> count=2, if_ready=0; a third pair C is ignored; release the stall -> A, then B, then a bubble (zeros) on consecutive cycles.
REQ-040 count=1 with simultaneous push and pop for 10 cycles using sequential PCs -> count stays 1; id_pc advances by 4 each cycle with no gaps or reordering across pointer wrap.
REQ-041 count=2 with flush=1 and if_valid=1 on the same cycle -> next cycle count=0, id_valid=0, id_inst=0, if_ready=1; the flushed-cycle pair never appears.
REQ-042 stall[1]=1 with if_valid=1 -> count unchanged; meanwhile the head pops normally when stall[2]=0.
REQ-043 rst=1 asserted with count=2 and stall[2]=1 -> next cycle all outputs at reset values; the first post-reset push appears after one cycle.
